// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event arbiter: event codes, tracker states
// and the per-key code priority helper.
package key_evt_pkg;

    localparam int CODE_W = 2;

    typedef enum logic [CODE_W-1:0] {
        EVT_PRESS   = 2'd0,
        EVT_LONG    = 2'd1,
        EVT_REPEAT  = 2'd2,
        EVT_RELEASE = 2'd3
    } evt_code_t;

    typedef enum logic [1:0] {
        TRK_IDLE      = 2'd0,
        TRK_HELD      = 2'd1,
        TRK_REPEATING = 2'd2
    } trk_state_t;

    // Lowest pending code wins, so a PRESS is always delivered before its RELEASE.
    function automatic evt_code_t lowest_code(input logic [3:0] pend);
        if (pend[0])      return EVT_PRESS;
        else if (pend[1]) return EVT_LONG;
        else if (pend[2]) return EVT_REPEAT;
        else              return EVT_RELEASE;
    endfunction

endpackage

// File: rtl/key_event_tracker.sv
// One key: turns a debounced level into PRESS/LONG/REPEAT/RELEASE pending bits.
// state         | meaning
// TRK_IDLE      | key released, counter parked at 0
// TRK_HELD      | pressed, counting towards LONG
// TRK_REPEATING | LONG issued, counting between REPEATs
module key_event_tracker
    import key_evt_pkg::*;
#(
    parameter logic [31:0] LONG_CYCLES   = 32'd50_000 * 1000,
    parameter logic [31:0] REPEAT_CYCLES = 32'd50_000 * 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [3:0] clr,
    output logic [3:0] pend,
    output logic       ovf_pulse
);

    trk_state_t  state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  raise;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TRK_IDLE;
            cnt   <= '0;
            pend  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= (pend & ~clr) | raise;
        end
    end

    // A raise onto a bit that stays set means the new event is merged away.
    assign ovf_pulse = |(raise & pend & ~clr);

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        raise   = '0;
        case (state)
            TRK_IDLE: begin
                if (level) begin
                    state_n          = TRK_HELD;
                    raise[EVT_PRESS] = 1'b1;
                end
            end
            TRK_HELD: begin
                if (!level) begin
                    state_n            = TRK_IDLE;
                    raise[EVT_RELEASE] = 1'b1;
                end else if (cnt == LONG_CYCLES - 32'd1) begin
                    state_n         = TRK_REPEATING;
                    raise[EVT_LONG] = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            TRK_REPEATING: begin
                if (!level) begin
                    state_n            = TRK_IDLE;
                    raise[EVT_RELEASE] = 1'b1;
                end else if (cnt == REPEAT_CYCLES - 32'd1) begin
                    raise[EVT_REPEAT] = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: state_n = TRK_IDLE;
        endcase
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Merges per-key events onto one valid/ready port with a round-robin pick
// and a sticky overflow flag for events lost to merging.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int          N_KEYS        = 4,
    parameter logic [31:0] LONG_CYCLES   = 32'd50_000 * 1000,
    parameter logic [31:0] REPEAT_CYCLES = 32'd50_000 * 200,
    localparam int         KEY_W         = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KEY_W-1:0]  evt_key,
    output logic [CODE_W-1:0] evt_code,
    output logic              overflow,
    input  logic              clear_ovf
);

    logic [3:0]        pend [N_KEYS];
    logic [3:0]        clr  [N_KEYS];
    logic [N_KEYS-1:0] ovf_vec;
    logic [KEY_W-1:0]  rr_ptr;
    logic [KEY_W-1:0]  sel_key;
    evt_code_t         sel_code;
    logic              found;
    logic              load;
    int                idx;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_trk
        key_event_tracker #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_trk (
            .clk      (clk),
            .reset    (reset),
            .level    (key_level[k]),
            .clr      (clr[k]),
            .pend     (pend[k]),
            .ovf_pulse(ovf_vec[k])
        );
    end

    assign load = !evt_valid || evt_ready;

    always_comb begin
        found    = 1'b0;
        sel_key  = '0;
        sel_code = EVT_PRESS;
        idx      = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_KEYS) idx = idx - N_KEYS;
            if (!found && (|pend[idx])) begin
                found    = 1'b1;
                sel_key  = idx[KEY_W-1:0];
                sel_code = lowest_code(pend[idx]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_KEYS; k++) clr[k] = '0;
        if (load && found) clr[sel_key][sel_code] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_key   <= '0;
            evt_code  <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_key   <= sel_key;
                    evt_code  <= sel_code;
                    rr_ptr    <= (sel_key == KEY_W'(N_KEYS - 1)) ? '0 : sel_key + 1'b1;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
            if (|ovf_vec)       overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

endmodule
